// File: rtl/l_mac_acc_if.sv
// l_mac_acc_if -- term/result bus of the saturating MAC accumulator.
//   master : term producer; drives in_valid, in_first, in_last, msu, init, a, b
//            and receives out_valid, out, ovf.
//   slave  : the accumulator itself (mirror of master).
// DW is the operand width, AW the accumulator/result width (AW = 2*DW).
interface l_mac_acc_if #(
  parameter int DW = 16,
  parameter int AW = 2 * DW
);
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic                 msu;
  logic signed [AW-1:0] init;
  logic signed [DW-1:0] a;
  logic signed [DW-1:0] b;
  logic                 out_valid;
  logic signed [AW-1:0] out;
  logic                 ovf;

  modport master (
    output in_valid, in_first, in_last, msu, init, a, b,
    input  out_valid, out, ovf
  );

  modport slave (
    input  in_valid, in_first, in_last, msu, init, a, b,
    output out_valid, out, ovf
  );
endinterface

// File: rtl/l_mac_acc.sv
// l_mac_acc -- two-stage saturating multiply-accumulate (L_mac / L_msu).
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : l_mac_acc_if.slave
//     in_valid/in_first/in_last/msu/init/a/b : one term per cycle, no backpressure
//     out_valid : one-cycle pulse per last term; out/ovf hold between pulses
// Stage 1 forms the doubled, saturated product; stage 2 adds or subtracts it
// into the accumulator with saturation and a sticky overflow flag.
// AW must equal 2*DW.
module l_mac_acc #(
  parameter int DW = 16,
  parameter int AW = 2 * DW
) (
  input logic        clk,
  input logic        reset,
  l_mac_acc_if.slave bus
);

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DW-1:0] OP_MIN  = {1'b1, {(DW-1){1'b0}}};

  // ---------------- stage 1: L_mult product ----------------
  logic signed [AW-1:0] prod_raw;
  logic signed [AW-1:0] prod_sat;
  logic                 prod_ovf;

  // The exact DW x DW product fits in AW bits; only doubling (-1)*(-1) overflows.
  assign prod_raw = bus.a * bus.b;

  // NOTE: every output of an always_comb gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prod_sat = prod_raw <<< 1;
    prod_ovf = 1'b0;
    if (bus.a == OP_MIN && bus.b == OP_MIN) begin
      prod_sat = ACC_MAX;
      prod_ovf = 1'b1;
    end
  end

  logic                 s1_valid;
  logic signed [AW-1:0] s1_p;
  logic                 s1_msu;
  logic                 s1_first;
  logic                 s1_last;
  logic signed [AW-1:0] s1_init;
  logic                 s1_povf;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_msu   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_init  <= '0;
      s1_povf  <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      // Qualifiers and init are only captured with a valid term.
      if (bus.in_valid) begin
        s1_p     <= prod_sat;
        s1_msu   <= bus.msu;
        s1_first <= bus.in_first;
        s1_last  <= bus.in_last;
        s1_init  <= bus.init;
        s1_povf  <= prod_ovf;
      end
    end
  end

  // ---------------- stage 2: saturating accumulate ----------------
  logic signed [AW-1:0] acc;
  logic                 sticky;
  logic signed [AW-1:0] src;
  logic signed [AW:0]   sum_wide;
  logic signed [AW-1:0] acc_next;
  logic                 sticky_next;

  assign src = s1_first ? s1_init : acc;

  always_comb begin
    // One guard bit is enough to detect overflow of a single add/subtract.
    sum_wide    = s1_msu ? ({src[AW-1], src} - {s1_p[AW-1], s1_p})
                         : ({src[AW-1], src} + {s1_p[AW-1], s1_p});
    acc_next    = sum_wide[AW-1:0];
    sticky_next = (s1_first ? 1'b0 : sticky) | s1_povf;
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      acc_next    = sum_wide[AW] ? ACC_MIN : ACC_MAX;
      sticky_next = 1'b1;
    end
  end

  // NOTE: reset clears every stage-2 register as well, so a vector open at
  // reset is abandoned and the accumulator restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      sticky        <= 1'b0;
      bus.out       <= '0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc    <= acc_next;
        sticky <= sticky_next;
        if (s1_last) begin
          bus.out <= acc_next;
          bus.ovf <= sticky_next;
        end
      end
    end
  end

endmodule
